// File: rtl/demux1x4_router.sv
// rtl/demux1x4_router.sv - registered 1-to-4 stream demultiplexer with per-channel FIFOs
module demux1x4_router #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic [1:0]                        in_sel,
  output logic [3:0]                        out_valid,
  input  logic [3:0]                        out_ready,
  output logic [4*WIDTH-1:0]                out_data,
  output logic [4*($clog2(DEPTH)+1)-1:0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q    [4][DEPTH];
  logic [AW-1:0]    rd_ptr_q [4];
  logic [AW-1:0]    rd_ptr_d [4];
  logic [AW-1:0]    wr_ptr_q [4];
  logic [AW-1:0]    wr_ptr_d [4];
  logic [LW-1:0]    level_q  [4];
  logic [LW-1:0]    level_d  [4];
  logic [3:0]       push;
  logic [3:0]       pop;

  // Readiness depends only on the addressed channel's stored level, never on out_ready.
  assign in_ready = (level_q[in_sel] != FULL);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      push[k]     = in_valid && in_ready && (in_sel == 2'(k));
      pop[k]      = out_valid[k] && out_ready[k];
      rd_ptr_d[k] = rd_ptr_q[k] + (pop[k]  ? AW'(1) : AW'(0));
      wr_ptr_d[k] = wr_ptr_q[k] + (push[k] ? AW'(1) : AW'(0));
      level_d[k]  = level_q[k];
      if (push[k] && !pop[k]) begin
        level_d[k] = level_q[k] + LW'(1);
      end else if (!push[k] && pop[k]) begin
        level_d[k] = level_q[k] - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        level_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        rd_ptr_q[k] <= rd_ptr_d[k];
        wr_ptr_q[k] <= wr_ptr_d[k];
        level_q[k]  <= level_d[k];
      end
    end
  end

  // Word storage carries no reset; emptiness is tracked solely by level_q.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= in_data;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_out
    assign out_valid[k]                = (level_q[k] != '0);
    assign out_data[k*WIDTH +: WIDTH]  = mem_q[k][rd_ptr_q[k]];
    assign level[k*LW +: LW]           = level_q[k];
  end

endmodule

// File: tb/tb_demux1x4_router.sv
// tb/tb_demux1x4_router.sv - randomized self-checking bench for demux1x4_router
module tb_demux1x4_router;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic [1:0]      in_sel = '0;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready = '0;
  logic [4*W-1:0]  out_data;
  logic [4*LW-1:0] level;

  int total = 0;
  int bad   = 0;

  // Reference: one plain queue per destination channel.
  logic [W-1:0] mq [4][$];

  demux1x4_router #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .level(level)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int k = 0; k < 4; k++) mq[k].delete();
  endtask

  task automatic tick(output bit acc);
    bit           pp [4];
    bit           ps;
    logic [1:0]   s;
    logic [W-1:0] d;
    s  = in_sel;
    d  = in_data;
    ps = in_valid && rst_n && (mq[s].size() < D);
    for (int k = 0; k < 4; k++) pp[k] = rst_n && out_ready[k] && (mq[k].size() > 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (pp[k]) void'(mq[k].pop_front());
    if (ps) mq[s].push_back(d);
    acc = ps;
  endtask

  task automatic test_reset();
    bit acc;
    in_valid = 1'b0;
    out_ready = 4'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    clear_model();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%h exp=00", level); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      total++;
      if (out_valid !== 4'b0000 || level !== '0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL idle_%0d got valid=%b level=%h ready=%b exp 0000/00/1", i, out_valid, level, in_ready);
      end
    end
  endtask

  task automatic test_routing();
    bit acc;
    out_ready = 4'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'(k);
      in_data  = 8'hA0 + 8'(k);
      tick(acc);
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL route_valid got=%b exp=1111", out_valid); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_data[k*W +: W] !== 8'hA0 + 8'(k)) begin
        bad++; $display("FAIL route_data%0d got=%h exp=%h", k, out_data[k*W +: W], 8'hA0 + 8'(k));
      end
      total++;
      if (level[k*LW +: LW] !== 2'd1) begin
        bad++; $display("FAIL route_level%0d got=%0d exp=1", k, level[k*LW +: LW]);
      end
    end
    out_ready = 4'b1111;
    tick(acc);
    out_ready = 4'b0;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL route_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_full();
    bit acc;
    out_ready = 4'b0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11; tick(acc);
    in_data = 8'h22; tick(acc);
    in_data = 8'h33;
    #1;
    total++; if (level[5:4] !== 2'd2) begin bad++; $display("FAIL full_level got=%0d exp=2", level[5:4]); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    in_sel = 2'd1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_other_sel got=%b exp=1", in_ready); end
    in_sel = 2'd2;
    out_ready = 4'b0100;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass got=%b exp=0", in_ready); end
    tick(acc);
    out_ready = 4'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b exp=1", in_ready); end
    total++; if (out_data[23:16] !== 8'h22) begin bad++; $display("FAIL full_head got=%h exp=22", out_data[23:16]); end
    total++; if (level[5:4] !== 2'd1) begin bad++; $display("FAIL full_level_after_pop got=%0d exp=1", level[5:4]); end
    out_ready = 4'b0100;
    tick(acc);
    out_ready = 4'b0;
  endtask

  task automatic test_push_pop();
    bit acc;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55; tick(acc);
    in_data = 8'h66; out_ready = 4'b0001; tick(acc);
    in_valid = 1'b0; out_ready = 4'b0;
    total++; if (level[1:0] !== 2'd1) begin bad++; $display("FAIL pp_level got=%0d exp=1", level[1:0]); end
    total++; if (out_data[7:0] !== 8'h66) begin bad++; $display("FAIL pp_head got=%h exp=66", out_data[7:0]); end
    total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL pp_valid got=%b exp=0001", out_valid); end
    out_ready = 4'b0001;
    tick(acc);
    out_ready = 4'b0;
  endtask

  task automatic test_wrap();
    bit acc;
    int next_in  = 0;
    int next_out = 0;
    int cycles   = 0;
    in_sel = 2'd3;
    while (next_out < 32 && cycles < 1000) begin
      in_valid  = (next_in < 32);
      in_data   = 8'(next_in);
      out_ready = {1'($urandom_range(0, 1)), 3'b000};
      #1;
      if (out_ready[3] && mq[3].size() > 0) begin
        total++;
        if (out_valid[3] !== 1'b1 || out_data[31:24] !== 8'(next_out)) begin
          bad++; $display("FAIL wrap_word got valid=%b data=%h exp=%h", out_valid[3], out_data[31:24], 8'(next_out));
        end
        next_out++;
      end
      tick(acc);
      if (acc) next_in++;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 4'b0;
    total++; if (next_out != 32) begin bad++; $display("FAIL wrap_timeout got=%0d exp=32", next_out); end
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL wrap_empty got=%b exp=0000", out_valid); end
  endtask

  task automatic test_random();
    bit acc;
    in_valid = 1'b1;
    in_sel   = 2'($urandom_range(0, 3));
    in_data  = 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      out_ready = 4'($urandom);
      #1;
      total++;
      if (in_ready !== (mq[in_sel].size() < D)) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, mq[in_sel].size() < D);
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (out_valid[k] !== (mq[k].size() > 0) || level[k*LW +: LW] !== 2'(mq[k].size())) begin
          bad++; $display("FAIL rnd_state c=%0d ch=%0d got valid=%b level=%0d exp level=%0d", c, k, out_valid[k], level[k*LW +: LW], mq[k].size());
        end
        if (mq[k].size() > 0) begin
          total++;
          if (out_data[k*W +: W] !== mq[k][0]) begin
            bad++; $display("FAIL rnd_data c=%0d ch=%0d got=%h exp=%h", c, k, out_data[k*W +: W], mq[k][0]);
          end
        end
      end
      tick(acc);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    tick(acc); tick(acc);
    out_ready = 4'b0;
  endtask

  task automatic test_reset_mid();
    bit acc;
    out_ready = 4'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h31; tick(acc);
    in_data = 8'h32; tick(acc);
    in_valid = 1'b0;
    total++; if (level[3:2] !== 2'd2) begin bad++; $display("FAIL rm_fill got=%0d exp=2", level[3:2]); end
    #3 rst_n = 1'b0;
    #1;
    clear_model();
    total++; if (level[3:2] !== 2'd0 || out_valid[1] !== 1'b0) begin
      bad++; $display("FAIL rm_cleared got level=%0d valid=%b exp 0/0", level[3:2], out_valid[1]);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h7E; tick(acc);
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b0010 || level[3:2] !== 2'd1) begin
      bad++; $display("FAIL rm_alone got valid=%b level=%0d exp 0010/1", out_valid, level[3:2]);
    end
    total++; if (out_data[15:8] !== 8'h7E) begin bad++; $display("FAIL rm_head got=%h exp=7e", out_data[15:8]); end
    out_ready = 4'b0010;
    tick(acc);
    out_ready = 4'b0;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rm_single got=%b exp=0000", out_valid); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_full();
    test_push_pop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
